// File: rtl/line_clear_pkg.sv
// line_clear shared definitions: board geometry and
// clearing FSM state encodings.
package line_clear_pkg;

    localparam int BOARD_WIDTH_BLK  = 10;
    localparam int BOARD_HEIGHT_BLK = 20;
    localparam int ROW_IDX_W        = $clog2(BOARD_HEIGHT_BLK);
    localparam int TOPOUT_ROWS_DEF  = 2;

    typedef enum logic [1:0] {
        LC_IDLE = 2'd0,
        LC_SCAN = 2'd1,
        LC_DONE = 2'd2
    } lc_state_t;

endpackage

// File: rtl/line_clear_row_full.sv
// Selects one row of the board by index and reports
// whether every cell in it is occupied.
module line_clear_row_full #(
    parameter int W  = 10,
    parameter int H  = 20,
    parameter int RW = $clog2(H)
) (
    input  logic [W*H-1:0] board,
    input  logic [RW-1:0]  row_idx,
    output logic           full
);

    logic [W-1:0] row;

    // mux out the addressed row and AND-reduce it
    always_comb begin
        row  = board[row_idx*W +: W];
        full = &row;
    end

endmodule

// File: rtl/line_clear.sv
// Registered stacked-block board: latches a committed board,
// removes full rows bottom-up, tracks totals and top-out.
module line_clear
    import line_clear_pkg::*;
#(
    parameter int BOARD_WIDTH  = BOARD_WIDTH_BLK,
    parameter int BOARD_HEIGHT = BOARD_HEIGHT_BLK,
    parameter int TOPOUT_ROWS  = TOPOUT_ROWS_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              commit,
    input  logic [BOARD_WIDTH*BOARD_HEIGHT-1:0] board_in,
    input  logic                              new_game,
    output logic [BOARD_WIDTH*BOARD_HEIGHT-1:0] board_out,
    output logic                              busy,
    output logic                              done,
    output logic [2:0]                        lines_cleared,
    output logic [15:0]                       lines_total,
    output logic                              game_over
);

    localparam int W  = BOARD_WIDTH;
    localparam int H  = BOARD_HEIGHT;
    localparam int RW = $clog2(H);

    lc_state_t        state_q;
    lc_state_t        state_d;
    logic [RW-1:0]    row_idx;
    logic [2:0]       count;
    logic             full;
    logic [W*H-1:0]   shifted;
    logic [16:0]      total_sum;
    logic             top_hit;

    line_clear_row_full #(
        .W  (W),
        .H  (H),
        .RW (RW)
    ) u_row_full (
        .board   (board_out),
        .row_idx (row_idx),
        .full    (full)
    );

    // rows at or above the scanned row drop by one; row 0 refills empty
    for (genvar r = 0; r < H; r++) begin : g_shift
        if (r == 0) begin : g_top
            assign shifted[0 +: W] = '0;
        end else begin : g_body
            assign shifted[r*W +: W] = (RW'(r) <= row_idx)
                ? board_out[(r-1)*W +: W]
                : board_out[r*W +: W];
        end
    end

    assign total_sum = {1'b0, lines_total} + 17'(count);
    assign top_hit   = |board_out[TOPOUT_ROWS*W-1:0];
    assign busy      = (state_q != LC_IDLE);
    assign done      = (state_q == LC_DONE);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state selection; new_game overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LC_IDLE: if (commit) state_d = LC_SCAN;
            LC_SCAN: if (!full && row_idx == '0) state_d = LC_DONE;
            LC_DONE: state_d = LC_IDLE;
            default: state_d = LC_IDLE;
        endcase
        if (new_game) state_d = LC_IDLE;
    end

    // board, scan pointer, counters and sticky top-out flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_out     <= '0;
            row_idx       <= '0;
            count         <= '0;
            lines_cleared <= '0;
            lines_total   <= '0;
            game_over     <= 1'b0;
        end else if (new_game) begin
            board_out   <= '0;
            row_idx     <= '0;
            count       <= '0;
            lines_total <= '0;
            game_over   <= 1'b0;
        end else begin
            unique case (state_q)
                LC_IDLE: begin
                    if (commit) begin
                        board_out <= board_in;
                        row_idx   <= RW'(H-1);
                        count     <= '0;
                    end
                end
                LC_SCAN: begin
                    if (full) begin
                        board_out <= shifted;
                        count     <= count + 3'd1;
                    end else if (row_idx != '0) begin
                        row_idx <= row_idx - RW'(1);
                    end else begin
                        lines_cleared <= count;
                        lines_total   <= total_sum[16] ? 16'hFFFF
                                                       : total_sum[15:0];
                        game_over     <= game_over | top_hit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: directed and random boards
// against a row-compaction reference model.
module tb_line_clear;

    localparam int W = 10;
    localparam int H = 20;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         rst;
    logic         commit;
    logic [N-1:0] board_in;
    logic         new_game;
    logic [N-1:0] board_out;
    logic         busy;
    logic         done;
    logic [2:0]   lines_cleared;
    logic [15:0]  lines_total;
    logic         game_over;

    int checks = 0;
    int fails  = 0;
    int m_total = 0;
    logic m_go = 1'b0;

    line_clear dut (
        .clk           (clk),
        .rst           (rst),
        .commit        (commit),
        .board_in      (board_in),
        .new_game      (new_game),
        .board_out     (board_out),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .lines_total   (lines_total),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    // Remove full rows and let surviving rows settle at the bottom
    function automatic void clear_model(input logic [N-1:0] b,
                                        output logic [N-1:0] r,
                                        output int n);
        logic [W-1:0] keep[$];
        logic [W-1:0] row;
        n = 0;
        r = '0;
        for (int y = H - 1; y >= 0; y--) begin
            row = b[y*W +: W];
            if (&row) n++;
            else keep.push_back(row);
        end
        foreach (keep[i]) r[(H-1-i)*W +: W] = keep[i];
    endfunction

    function automatic logic [N-1:0] rand_board();
        logic [N-1:0] b;
        logic [W-1:0] row;
        int nf;
        b = '0;
        nf = 0;
        for (int y = H - 1; y >= 8; y--) begin
            if (nf < 4 && $urandom_range(0, 3) == 0) begin
                row = '1;
                nf++;
            end else begin
                row = W'($urandom);
                if (&row) row[$urandom_range(0, W-1)] = 1'b0;
            end
            b[y*W +: W] = row;
        end
        return b;
    endfunction

    function automatic logic [N-1:0] put_row(input logic [N-1:0] b,
                                             input int y,
                                             input logic [W-1:0] v);
        logic [N-1:0] t;
        t = b;
        t[y*W +: W] = v;
        return t;
    endfunction

    // One commit: checks register latency, clear latency and results
    task automatic do_op(input logic [N-1:0] b, input string tag);
        logic [N-1:0] exp_b;
        int n;
        int cyc;
        clear_model(b, exp_b, n);
        m_total = (m_total + n > 65535) ? 65535 : m_total + n;
        m_go    = m_go | (|exp_b[2*W-1:0]);
        @(negedge clk);
        board_in = b;
        commit   = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        cyc = 1;
        checks++;
        if (board_out !== b) begin
            fails++;
            $display("FAIL %s latch: got %h want %h", tag, board_out, b);
        end
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== H + n + 1) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", tag, cyc, H + n + 1);
        end
        checks++;
        if (lines_cleared !== 3'(n)) begin
            fails++;
            $display("FAIL %s lines_cleared: got %0d want %0d",
                     tag, lines_cleared, n);
        end
        checks++;
        if (board_out !== exp_b) begin
            fails++;
            $display("FAIL %s board: got %h want %h", tag, board_out, exp_b);
        end
        checks++;
        if (lines_total !== 16'(m_total)) begin
            fails++;
            $display("FAIL %s total: got %0d want %0d", tag, lines_total, m_total);
        end
        checks++;
        if (game_over !== m_go) begin
            fails++;
            $display("FAIL %s game_over: got %b want %b", tag, game_over, m_go);
        end
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_in_done: got %b want 1", tag, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0/0",
                     tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        commit   = 1'b0;
        new_game = 1'b0;
        board_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (board_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_a: got b=%h busy=%b done=%b want 0",
                     board_out, busy, done);
        end
        checks++;
        if (lines_cleared !== 3'd0 || lines_total !== 16'd0 ||
            game_over !== 1'b0) begin
            fails++;
            $display("FAIL reset_b: got lc=%0d lt=%0d go=%b want 0",
                     lines_cleared, lines_total, game_over);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_line();
        do_op(put_row('0, 19, '1), "single");
    endtask

    task automatic test_four_lines();
        logic [N-1:0] b;
        b = '0;
        for (int y = 16; y <= 19; y++) b = put_row(b, y, '1);
        b = put_row(b, 15, 10'b0000000001);
        do_op(b, "four");
        checks++;
        if (board_out[19*W +: W] !== 10'b0000000001) begin
            fails++;
            $display("FAIL four_row19: got %b want 0000000001",
                     board_out[19*W +: W]);
        end
    endtask

    task automatic test_split_lines();
        logic [N-1:0] b;
        b = put_row('0, 19, '1);
        b = put_row(b, 17, '1);
        b = put_row(b, 18, 10'b1111111110);
        do_op(b, "split");
        checks++;
        if (board_out[19*W +: W] !== 10'b1111111110) begin
            fails++;
            $display("FAIL split_row19: got %b want 1111111110",
                     board_out[19*W +: W]);
        end
    endtask

    task automatic test_no_clear_topout();
        logic [N-1:0] b;
        b = put_row('0, 0, 10'b0000010000);
        b = put_row(b, 12, 10'b0110011000);
        do_op(b, "topout");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) do_op(rand_board(), "random");
    endtask

    task automatic test_commit_ignored_new_game();
        logic [N-1:0] b2;
        logic saw_done;
        b2 = put_row('0, 5, 10'b1010101010);
        saw_done = 1'b0;
        @(negedge clk);
        board_in = put_row('0, 19, '1);
        commit   = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (done) saw_done = 1'b1;
            if (c == 6) begin
                checks++;
                if (board_out !== '0 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL ignored_commit: got b=%h busy=%b want 0/1",
                             board_out, busy);
                end
            end
            board_in = (c == 5) ? b2 : '0;
            commit   = (c == 5);
            new_game = (c == 10);
            @(negedge clk);
        end
        commit   = 1'b0;
        new_game = 1'b0;
        m_total  = 0;
        m_go     = 1'b0;
        checks++;
        if (saw_done !== 1'b0) begin
            fails++;
            $display("FAIL new_game_done: got pulse want none");
        end
        checks++;
        if (board_out !== '0 || busy !== 1'b0 || game_over !== 1'b0 ||
            lines_total !== 16'd0) begin
            fails++;
            $display("FAIL new_game_clear: got b=%h busy=%b go=%b lt=%0d want 0",
                     board_out, busy, game_over, lines_total);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [N-1:0] b;
        do_op(put_row('0, 19, '1), "pre_rst");
        b = put_row('0, 19, '1);
        b = put_row(b, 10, 10'b0011001100);
        @(negedge clk);
        board_in = b;
        commit   = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || board_out === '0) begin
            fails++;
            $display("FAIL mid_scan: got busy=%b b=%h want busy 1, b!=0",
                     busy, board_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (board_out !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            lines_total !== 16'd0 || lines_cleared !== 3'd0 ||
            game_over !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: got b=%h busy=%b lt=%0d lc=%0d want 0",
                     board_out, busy, lines_total, lines_cleared);
        end
        @(negedge clk);
        rst = 1'b0;
        m_total = 0;
        m_go    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        logic [N-1:0] b;
        force dut.lines_total = 16'hFFFE;
        @(negedge clk);
        release dut.lines_total;
        m_total = 16'hFFFE;
        b = '0;
        for (int y = 16; y <= 19; y++) b = put_row(b, y, '1);
        do_op(b, "sat4");
        do_op(put_row('0, 19, '1), "sat1");
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_four_lines();
        test_split_lines();
        test_no_clear_topout();
        test_random();
        test_commit_ignored_new_game();
        test_reset_mid_scan();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
